// File: rtl/unique_list_streamer.sv
// Reads the engine's unique list through a 1-cycle read port and streams it with last/sum/max.
// Two-deep skid FIFO plus in-flight credit keeps one beat per cycle and holds data under backpressure.
module unique_list_streamer #(
  parameter int buff_size = 128,
  parameter int word_size = 32,
  parameter int addr_w    = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [31:0]               count,
  output logic                      rd_en,
  output logic [addr_w-1:0]         rd_addr,
  input  logic [word_size-1:0]      rd_data,
  output logic [word_size-1:0]      out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy,
  output logic                      list_done,
  output logic [word_size+addr_w:0] sum,
  output logic [word_size-1:0]      max_val
);

  localparam int cw = addr_w + 1;

  typedef enum logic {st_idle, st_run} state_t;

  state_t               state, state_nxt;
  logic [cw-1:0]        cnt, rd_idx, out_idx, count_clamp;
  logic [1:0]           occ;
  logic                 inflight;
  logic [2:0]           credit_use;
  logic [word_size-1:0] fifo_mem [2];
  logic                 wr_ptr, rd_ptr;
  logic                 pop;
  logic [word_size-1:0] head;

  assign count_clamp = (count > 32'(buff_size)) ? cw'(buff_size) : count[cw-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= st_idle;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    head       = fifo_mem[rd_ptr];
    out_valid  = (occ != 2'd0);
    out_data   = out_valid ? head : '0;
    out_last   = out_valid && (out_idx == cnt - cw'(1));
    pop        = out_valid && out_ready;
    busy       = (state == st_run);
    // Entries already owed to the FIFO after this cycle's pop; a new read needs a free slot.
    credit_use = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    rd_en      = busy && (rd_idx < cnt) && (credit_use < 3'd2);
    rd_addr    = rd_idx[addr_w-1:0];
    case (state)
      st_idle: if (start && (count_clamp != '0)) state_nxt = st_run;
      st_run:  if (pop && out_last)              state_nxt = st_idle;
      default: state_nxt = st_idle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      rd_idx      <= '0;
      out_idx     <= '0;
      occ         <= '0;
      inflight    <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      list_done   <= 1'b0;
      sum         <= '0;
      max_val     <= '0;
    end else begin
      list_done <= 1'b0;
      if (state == st_idle && start) begin
        cnt     <= count_clamp;
        rd_idx  <= '0;
        out_idx <= '0;
        sum     <= '0;
        max_val <= '0;
        if (count_clamp == '0) list_done <= 1'b1;
      end
      inflight <= rd_en;
      if (rd_en) rd_idx <= rd_idx + cw'(1);
      if (inflight) begin
        fifo_mem[wr_ptr] <= rd_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr  <= ~rd_ptr;
        out_idx <= out_idx + cw'(1);
        sum     <= sum + {{cw{1'b0}}, head};
        if (head > max_val) max_val <= head;
        if (out_last) list_done <= 1'b1;
      end
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_unique_list_streamer.sv
// Directed-plus-random bench for unique_list_streamer against a queue-based reference of the unique list.
module tb_unique_list_streamer;
  logic        clk = 1'b0;
  logic        rst, start, rd_en, out_valid, out_ready, out_last, busy, list_done;
  logic [31:0] count, rd_data, out_data, max_val;
  logic [6:0]  rd_addr;
  logic [39:0] sum;

  int total = 0, passed = 0, cyc = 0;
  logic [31:0] buf_mem [128];
  logic [31:0] exp_q[$];
  logic [31:0] beat_q[$];
  bit          last_q[$];
  int rd_cnt, popped, max_ahead, addr_err, stall_err, dones;
  int first_cyc, last_beat_cyc, done_cyc, start_cyc;
  bit prev_vld, prev_rdy, prev_last;
  logic [31:0] prev_dat;
  longint      exp_sum;
  logic [31:0] exp_max;

  unique_list_streamer dut (
    .clk(clk), .rst(rst), .start(start), .count(count),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .list_done(list_done), .sum(sum), .max_val(max_val)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rd_en) rd_data <= buf_mem[rd_addr];

  // Observer: records accepted beats, read ordering, credit depth and stall stability.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      prev_vld = 1'b0;
    end else begin
      if (rd_en === 1'b1) begin
        if (rd_addr !== 7'(rd_cnt)) addr_err++;
        rd_cnt++;
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        beat_q.push_back(out_data);
        last_q.push_back(out_last);
        if (first_cyc < 0) first_cyc = cyc;
        last_beat_cyc = cyc;
        popped++;
      end
      if (rd_cnt - popped > max_ahead) max_ahead = rd_cnt - popped;
      if (prev_vld && !prev_rdy)
        if (out_valid !== 1'b1 || out_data !== prev_dat || out_last !== prev_last) stall_err++;
      prev_vld  = (out_valid === 1'b1);
      prev_rdy  = (out_ready === 1'b1);
      prev_dat  = out_data;
      prev_last = (out_last === 1'b1);
      if (list_done === 1'b1) dones++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 128; i++) buf_mem[i] = $urandom;
  endtask

  task automatic start_list(input int n);
    int m;
    m = (n > 128) ? 128 : n;
    exp_q.delete(); beat_q.delete(); last_q.delete();
    rd_cnt = 0; popped = 0; max_ahead = 0; addr_err = 0; stall_err = 0; dones = 0;
    first_cyc = -1; last_beat_cyc = -1; done_cyc = -1;
    exp_sum = 0; exp_max = 0;
    for (int i = 0; i < m; i++) begin
      exp_q.push_back(buf_mem[i]);
      exp_sum += buf_mem[i];
      if (buf_mem[i] > exp_max) exp_max = buf_mem[i];
    end
    count = n; start = 1'b1; start_cyc = cyc;
  endtask

  // mode 0: ready high; 1: random ready; 2: ready low for 4 cycles after the first beat.
  task automatic wait_done(input int mode, input bit mid_start);
    int stall_left;
    bit seen;
    stall_left = 4; seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        check("rd_en_first_cycle", rd_en, exp_q.size() != 0);
        check("busy_first_cycle", busy, exp_q.size() != 0);
      end
      start = 1'b0;
      if (mid_start && k == 2) begin start = 1'b1; count = 1; end
      if (list_done === 1'b1) begin
        seen = 1'b1; done_cyc = cyc;
      end else begin
        case (mode)
          0: out_ready = 1'b1;
          1: out_ready = ($urandom_range(0, 3) != 0);
          default: begin
            if (beat_q.size() >= 1 && stall_left > 0) begin
              out_ready = 1'b0;
              stall_left--;
              if (stall_left == 1) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, exp_q[1]);
              end
            end else out_ready = 1'b1;
          end
        endcase
      end
    end
    check("done_seen", seen, 1);
  endtask

  task automatic verify(input int mode);
    int n, derr, lerr;
    n = exp_q.size(); derr = 0; lerr = 0;
    check("beat_count", beat_q.size(), n);
    for (int i = 0; i < n && i < beat_q.size(); i++) begin
      if (beat_q[i] !== exp_q[i]) derr++;
      if (last_q[i] != (i == n - 1)) lerr++;
    end
    check("data_order", derr, 0);
    check("last_flag", lerr, 0);
    check("sum", sum, exp_sum);
    check("max_val", max_val, exp_max);
    check("credit_ahead_le2", max_ahead <= 2, 1);
    check("rd_addr_seq", addr_err, 0);
    check("rd_count", rd_cnt, n);
    check("stall_hold", stall_err, 0);
    if (n > 0) check("done_after_last", done_cyc, last_beat_cyc + 1);
    else       check("done_after_start", done_cyc, start_cyc + 1);
    if (mode == 0 && n > 0) check("back_to_back", last_beat_cyc - first_cyc, n - 1);
  endtask

  task automatic post_idle();
    @(posedge clk); #1;
    check("done_single", list_done, 0);
    check("busy_idle", busy, 0);
    check("valid_idle", out_valid, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_list_done"}, list_done, 0);
    check({tag, "_sum"}, sum, 0);
    check({tag, "_max_val"}, max_val, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; count = 0; out_ready = 1'b0;
    for (int i = 0; i < 128; i++) buf_mem[i] = '0;
    #12;
    check_all_zero("reset");
    @(posedge clk); #1; rst = 1'b1;

    buf_mem[0] = 2; buf_mem[1] = 5; buf_mem[2] = 9;
    start_list(3); wait_done(0, 1'b0); verify(0);
    check("sum_2_5_9", sum, 16);
    check("max_2_5_9", max_val, 9);
    post_idle();

    start_list(3); wait_done(2, 1'b0); verify(2); post_idle();

    start_list(0); wait_done(0, 1'b0); verify(0); post_idle();

    for (int i = 0; i < 128; i++) buf_mem[i] = i;
    start_list(200); wait_done(0, 1'b0); verify(0);
    check("sum_0_to_127", sum, 8128);
    check("max_0_to_127", max_val, 127);
    post_idle();

    fill_rand();
    start_list(20); wait_done(1, 1'b1); verify(1); post_idle();

    fill_rand();
    start_list(7); wait_done(1, 1'b0); verify(1);
    start_list($urandom_range(1, 10)); wait_done(0, 1'b0); verify(0); post_idle();

    repeat (3) begin
      fill_rand();
      start_list($urandom_range(0, 140)); wait_done(1, 1'b0); verify(1); post_idle();
    end

    fill_rand();
    start_list(5); out_ready = 1'b1;
    for (int k = 0; k < 20 && beat_q.size() < 1; k++) begin
      @(posedge clk); #1; start = 1'b0;
    end
    check("beat1_before_reset", beat_q.size(), 1);
    check("beat2_valid", out_valid, 1);
    rst = 1'b0; #1;
    check_all_zero("midreset");
    repeat (3) @(posedge clk);
    #1;
    check("no_done_in_reset", dones, 0);
    rst = 1'b1;
    start_list(5); wait_done(0, 1'b0); verify(0); post_idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
